// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: instruction-memory request/response channel plus the IF/ID-facing outputs
// and the hazard/redirect controls of the fetch stage.
interface if_fetch_unit_if;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic [31:0] PC_out;
    logic [31:0] Instruction_out;
    modport master (
        input  freeze, branch_taken, branch_addr, imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output imem_req_valid, imem_addr, if_valid, PC_out, Instruction_out
    );
    modport slave (
        output freeze, branch_taken, branch_addr, imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  imem_req_valid, imem_addr, if_valid, PC_out, Instruction_out
    );
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: credit-limited in-order instruction fetch with a small output FIFO,
// freeze hold and branch redirect that drops stale in-flight responses.
module if_fetch_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic             clk,
    input logic             rst,
    if_fetch_unit_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    logic [31:0]   r_pc;
    logic [31:0]   r_rsp_pc;
    logic [AW:0]   r_out;
    logic [AW:0]   r_drop;
    logic [AW:0]   r_cnt;
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [63:0]   r_mem [DEPTH];
    logic [AW+1:0] w_used;
    logic          w_acc;
    logic          w_rsp;
    logic          w_push;
    logic          w_pop;
    assign w_used             = {1'b0, r_out} + {1'b0, r_cnt};
    assign bus.imem_req_valid = rst && !bus.branch_taken && (w_used < (AW+2)'(DEPTH));
    assign bus.imem_addr      = r_pc;
    assign w_acc              = bus.imem_req_valid && bus.imem_req_ready;
    assign w_rsp              = bus.imem_rsp_valid;
    assign w_push             = w_rsp && !bus.branch_taken && (r_drop == '0);
    assign bus.if_valid       = r_cnt != '0;
    assign w_pop              = bus.if_valid && !bus.freeze && !bus.branch_taken;
    assign bus.PC_out          = bus.if_valid ? r_mem[r_rd][63:32] : '0;
    assign bus.Instruction_out = bus.if_valid ? r_mem[r_rd][31:0] : '0;
    // r_rsp_pc is the PC of the next response that will be kept; stale ones never advance it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc     <= RESET_PC;
            r_rsp_pc <= RESET_PC;
            r_out    <= '0;
            r_drop   <= '0;
            r_cnt    <= '0;
            r_rd     <= '0;
            r_wr     <= '0;
        end else begin
            r_out <= r_out + (AW+1)'(w_acc) - (AW+1)'(w_rsp);
            if (bus.branch_taken) begin
                r_pc     <= bus.branch_addr;
                r_rsp_pc <= bus.branch_addr;
                r_drop   <= r_out - (AW+1)'(w_rsp);
                r_cnt    <= '0;
                r_rd     <= '0;
                r_wr     <= '0;
            end else begin
                if (w_acc) r_pc <= r_pc + 32'd4;
                if (w_rsp && r_drop != '0) r_drop <= r_drop - (AW+1)'(1);
                if (w_push) r_rsp_pc <= r_rsp_pc + 32'd4;
                if (w_push) r_wr <= r_wr + AW'(1);
                if (w_pop) r_rd <= r_rd + AW'(1);
                r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= {r_rsp_pc + 32'd4, bus.imem_rsp_data};
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: random and directed fetch traffic checked against a queue-based reference
// model of requests in flight and presented words; a second instance checks PC wraparound.
module tb_if_fetch_unit;
    localparam int DEPTH = 2;
    logic clk = 0;
    logic rst = 0;
    logic rst2 = 0;
    always #5 clk = ~clk;
    if_fetch_unit_if bus ();
    if_fetch_unit_if bus2 ();
    if_fetch_unit #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus.master));
    if_fetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut2 (.clk(clk), .rst(rst2), .bus(bus2.master));
    typedef struct {logic [31:0] addr; bit stale;} req_t;
    typedef struct {logic [31:0] addr; int due;} mreq_t;
    req_t        pend[$];
    logic [63:0] ofifo[$];
    mreq_t       mem[$];
    logic [31:0] m_pc;
    int cyc = 0, lat = 1, last_due = -1, nchk = 0, nfail = 0;
    always @(posedge clk) begin
        bus2.imem_rsp_valid <= rst2 && bus2.imem_req_valid && bus2.imem_req_ready;
        bus2.imem_rsp_data  <= bus2.imem_addr >> 2;
    end
    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic idle();
        bus.freeze = 0; bus.branch_taken = 0; bus.branch_addr = 0; bus.imem_req_ready = 1;
        bus.imem_rsp_valid = 0; bus.imem_rsp_data = 0;
    endtask
    task automatic do_reset();
        idle();
        rst = 0;
        #1;
        chk("rst_if_valid", bus.if_valid, 0);
        chk("rst_req_valid", bus.imem_req_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1;
        pend.delete(); ofifo.delete(); mem.delete();
        m_pc = 0; last_due = -1;
    endtask
    task automatic cycle(bit frz, bit br, logic [31:0] ba, bit rdy);
        bit rv, ev, acc;
        logic [31:0] rd;
        req_t p;
        int due;
        rv = 0; rd = 0;
        if (mem.size() != 0 && mem[0].due <= cyc) begin
            rd = mem[0].addr >> 2;
            void'(mem.pop_front());
            rv = 1;
        end
        bus.freeze = frz; bus.branch_taken = br; bus.branch_addr = ba; bus.imem_req_ready = rdy;
        bus.imem_rsp_valid = rv; bus.imem_rsp_data = rd;
        ev = !br && (pend.size() + ofifo.size() < DEPTH);
        @(negedge clk);
        chk("req_valid", bus.imem_req_valid, ev);
        if (ev) chk("imem_addr", bus.imem_addr, m_pc);
        chk("if_valid", bus.if_valid, ofifo.size() != 0);
        chk("pc_out", bus.PC_out, ofifo.size() != 0 ? ofifo[0][63:32] : 32'h0);
        chk("instr", bus.Instruction_out, ofifo.size() != 0 ? ofifo[0][31:0] : 32'h0);
        chk("fifo_cnt", 32'(dut.r_cnt), ofifo.size());
        @(posedge clk);
        #1;
        acc = ev && rdy;
        if (ofifo.size() != 0 && !frz && !br) void'(ofifo.pop_front());
        if (rv) begin
            p = pend.pop_front();
            if (!br && !p.stale) ofifo.push_back({p.addr + 32'd4, rd});
        end
        if (br) begin
            ofifo.delete();
            foreach (pend[i]) pend[i].stale = 1;
            m_pc = ba;
        end
        if (acc) begin
            due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            last_due = due;
            pend.push_back('{m_pc, 1'b0});
            mem.push_back('{m_pc, due});
            m_pc += 32'd4;
        end
        cyc++;
    endtask
    always @(negedge clk) if (rst) assert (dut.r_cnt <= DEPTH);
    initial begin
        logic [31:0] qa[$];
        logic [31:0] qp[$];
        logic [31:0] ea[3];
        logic [31:0] ep[3];
        logic [31:0] ba;
        int n;
        bus2.freeze = 0; bus2.branch_taken = 0; bus2.branch_addr = 0; bus2.imem_req_ready = 1;
        do_reset();
        chk("rst_addr", bus.imem_addr, 0);
        lat = 1;
        repeat (12) cycle(0, 0, 0, 1);
        repeat (5) cycle(1, 0, 0, 1);
        repeat (8) cycle(0, 0, 0, 1);
        do_reset();
        lat = 3;
        repeat (2) cycle(0, 0, 0, 1);
        chk("two_outstanding", 32'(dut.r_out), 2);
        cycle(0, 1, 32'h100, 1);
        repeat (12) cycle(0, 0, 0, 1);
        do_reset();
        lat = 2;
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 32'h200, 1);
        chk("drop_zero", 32'(dut.r_drop), 0);
        chk("out_zero", 32'(dut.r_out), 0);
        repeat (6) cycle(0, 0, 0, 1);
        repeat (6) begin
            lat = $urandom_range(1, 4);
            repeat (300) begin
                ba = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
                cycle($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, ba, $urandom_range(0, 3) != 0);
            end
        end
        lat = 1;
        n = 0;
        while (ofifo.size() < 2 && n < 50) begin
            cycle(1, 0, 0, 1);
            n++;
        end
        chk("fill_before_reset", ofifo.size(), 2);
        idle();
        #2 rst = 0;
        #1;
        chk("async_if_valid", bus.if_valid, 0);
        chk("async_pc_out", bus.PC_out, 0);
        chk("async_instr", bus.Instruction_out, 0);
        chk("async_req_valid", bus.imem_req_valid, 0);
        do_reset();
        chk("post_rst_addr", bus.imem_addr, 0);
        repeat (6) cycle(0, 0, 0, 1);
        @(posedge clk);
        #1 rst2 = 1;
        repeat (8) begin
            @(negedge clk);
            if (bus2.imem_req_valid) qa.push_back(bus2.imem_addr);
            if (bus2.if_valid) qp.push_back(bus2.PC_out);
        end
        ea[0] = 32'hFFFF_FFF8; ea[1] = 32'hFFFF_FFFC; ea[2] = 32'h0000_0000;
        ep[0] = 32'hFFFF_FFFC; ep[1] = 32'h0000_0000; ep[2] = 32'h0000_0004;
        chk("wrap_addr_count", qa.size() >= 3, 1);
        chk("wrap_pc_count", qp.size() >= 3, 1);
        for (int i = 0; i < 3; i++) begin
            if (i < qa.size()) chk("wrap_addr", qa[i], ea[i]);
            if (i < qp.size()) chk("wrap_pc", qp[i], ep[i]);
        end
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues in-order requests to a variable-latency instruction memory.
- Buffers returned words in a small FIFO and presents {PC+4, Instruction} to the IF/ID register.
- Handles freeze (hazard stall) and branch redirect, including discarding stale in-flight responses.

Parameters:
- DEPTH, 2, FIFO entries; also the cap on (outstanding requests + buffered words). Must be a power of 2, at least 2.
- RESET_PC, 32'h0000_0000, fetch PC after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- freeze  in  1  downstream stall: hold the presented word.
- branch_taken  in  1  redirect fetch this cycle.
- branch_addr  in  32  redirect target, word aligned.
- imem_req_valid  out  1  fetch request.
- imem_req_ready  in  1  memory accepts the request.
- imem_addr  out  32  request address (the fetch PC).
- imem_rsp_valid  in  1  one-cycle response pulse, in order, no backpressure.
- imem_rsp_data  in  32  returned instruction.
- if_valid  out  1  PC_out and Instruction_out are meaningful.
- PC_out  out  32  address of the presented instruction + 4.
- Instruction_out  out  32  presented instruction; 0 when if_valid=0.

Behaviour:
- Reset (rst=0, asynchronous):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0.
  - if_valid=0, PC_out=0, Instruction_out=0, imem_req_valid=0.
  - The memory shares rst, so no response arrives from before reset.
- Counters: outstanding and drop_cnt are clog2(DEPTH)+1 bits wide. drop_cnt never exceeds outstanding.
- Issue:
  - imem_req_valid = !branch_taken && (outstanding + fifo_count < DEPTH). This is combinational.
  - imem_addr = fetch_pc.
  - Accept means valid && ready. On accept: fetch_pc += 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0), and outstanding += 1.
  - freeze does not block issue; only the credit limit does.
- Response (imem_rsp_valid=1):
  - outstanding -= 1.
  - If drop_cnt > 0: drop_cnt -= 1 and discard the data.
  - Otherwise push {resp_pc + 4, data}. resp_pc is tracked by an internal in-order PC queue, or by a separate counter that is reset on redirect.
  - Credits guarantee the FIFO never overflows; the bench asserts this.
  - If accept and response occur in the same cycle, the net change to outstanding is 0.
- Output:
  - if_valid = FIFO non-empty.
  - PC_out and Instruction_out show the FIFO head, or 0 when empty.
  - Pop when if_valid && !freeze && !branch_taken.
  - No bypass: a word received in cycle N is presented in cycle N+1 at the earliest.
  - Minimum fetch latency is request accept + memory latency L + 1 cycle.
- Redirect (branch_taken=1):
  - That cycle: no request issued, no pop, and any response arriving is discarded.
  - At the clock edge:
    - FIFO is cleared.
    - fetch_pc = branch_addr.
    - drop_cnt = outstanding − (imem_rsp_valid ? 1 : 0), including any previously pending drops.
    - outstanding is decremented normally.
  - branch_taken overrides freeze.
  - A second branch while drops are still pending recomputes drop_cnt by the same rule.
- The freeze, branch and response simultaneous cases are all covered by the rules above. No other priorities apply.

Test Plan:
- Reset with rst=0 mid-stream (FIFO holding 2 words) → all outputs 0 immediately, asynchronously. After release, first imem_addr=0.
- Memory L=1, ready always 1, memory returns addr>>2 → consecutive PC_out = 4, 8, 12, … and Instruction_out = 0, 1, 2, …, one word per cycle after the first. if_valid goes high 2 cycles after the first accept.
- freeze=1 for 5 cycles with DEPTH=2 → PC_out/Instruction_out held. imem_req_valid drops once outstanding+count=2. After release, the sequence resumes with no gap or duplicate.
- Memory L=3, branch_taken with branch_addr=0x100 while 2 requests are outstanding → those 2 responses are dropped. Next valid output is PC_out=0x104 with the instruction at 0x100. No request is issued in the branch cycle.
- Branch at the same cycle as imem_rsp_valid, with 1 outstanding → that response is dropped, drop_cnt=0, and fetching resumes from the target the next cycle.
- RESET_PC=32'hFFFF_FFF8 → imem_addr sequence FFFF_FFF8, FFFF_FFFC, 0000_0000. PC_out sequence FFFF_FFFC, 0000_0000, 0000_0004.
